sc_fifo_param: RTL and testbench

Parametrised single-clock FIFO for the JPEG encoder glue logic. It buffers words between the OV7670 capture path, the encoder core and the ESP32 output interface. It succeeds the fixed 32-bit/128-deep FIFO with:
- independent width and depth parameters;
- programmable almost-full and almost-empty thresholds;
- guarded read and write with sticky overflow and underflow flags;
- an optional first-word-fall-through (FWFT) output.

---
 rtl/sc_fifo_param_if.sv | 34 +++
 rtl/sc_fifo_param.sv | 130 +++++++++++++
 tb/tb_sc_fifo_param.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_fifo_param_if.sv
// Handshake bundle for sc_fifo_param: producer/consumer controls on the master
// side, data and status returned from the FIFO on the slave side.
interface sc_fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  // write/read are single-cycle requests sampled at the rising edge; a request
  // is accepted only when the FIFO can honour it (no ready signal, status
  // outputs tell the requester whether it will be accepted).
  logic                  clear;
  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   cnt;

  modport master (
    output clear, write, data_in, read,
    input  data_out, full, empty, almost_full, almost_empty,
           overflow, underflow, cnt
  );

  modport slave (
    input  clear, write, data_in, read,
    output data_out, full, empty, almost_full, almost_empty,
           overflow, underflow, cnt
  );
endinterface

// File: rtl/sc_fifo_param.sv
// Parametrised single-clock FIFO with registered (block-RAM style) read port.
// Define SC_FIFO_FWFT_EN for first-word-fall-through output; default is standard mode.
module sc_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  sc_fifo_param_if.slave bus
);

  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_T    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_T    = AE_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_mem_rd;

  assign w_full  = (r_cnt == DEPTH_C);
  assign w_rd_ok = bus.read & ~w_empty;
  assign w_wr_ok = bus.write & (~w_full | w_rd_ok);

`ifdef SC_FIFO_FWFT_EN
  // r_ov marks a valid word in the output register; r_cnt counts it too, so
  // the memory holds r_cnt - r_ov words.
  logic                r_ov;
  logic [ADDR_WIDTH:0] w_mem_cnt;

  assign w_mem_cnt = r_cnt - {{ADDR_WIDTH{1'b0}}, r_ov};
  assign w_empty   = ~r_ov;
  assign w_mem_rd  = ~bus.clear & (w_mem_cnt != '0) & (~r_ov | w_rd_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ov <= 1'b0;
    end else if (bus.clear) begin
      r_ov <= 1'b0;
    end else if (w_mem_rd) begin
      r_ov <= 1'b1;
    end else if (w_rd_ok) begin
      r_ov <= 1'b0;
    end
  end
`else
  assign w_empty  = (r_cnt == '0);
  assign w_mem_rd = ~bus.clear & w_rd_ok;
`endif

  // Storage write port; memory is deliberately left out of reset and clear.
  always_ff @(posedge clk) begin
    if (w_wr_ok & ~bus.clear) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  // Registered read port; on a full FIFO with simultaneous write the pointers
  // coincide and this read returns the old head word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout <= '0;
    end else if (w_mem_rd) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (bus.clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_mem_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (bus.clear) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.write & ~w_wr_ok) begin
        r_ovf <= 1'b1;
      end
      if (bus.read & w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign bus.data_out     = r_dout;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_cnt >= AF_T);
  assign bus.almost_empty = (r_cnt <= AE_T);
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
  assign bus.cnt          = r_cnt;

endmodule

// File: tb/tb_sc_fifo_param.sv
// Directed bench for sc_fifo_param with DEPTH=8, AF=6, AE=2; the standard-mode
// sequence runs by default, the FWFT sequence when SC_FIFO_FWFT_EN is defined.
module tb_sc_fifo_param;
  localparam int DW = 8;
  localparam int AW = 3;

  logic clk;
  logic reset;

  sc_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sc_fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  int            m_cnt;
  logic          m_ovf;
  logic          m_udf;
  logic [DW-1:0] m_dout;
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  // Driver: one clock of stimulus, model updated, outputs sampled 1ns after the edge
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    logic rd_ok;
    logic wr_ok;
    @(negedge clk);
    bus.write   = wr;
    bus.data_in = d;
    bus.read    = rd;
    bus.clear   = clr;
    rd_ok = rd && (m_cnt != 0);
    wr_ok = wr && ((m_cnt != 8) || rd_ok);
    if (clr) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && (m_cnt == 0)) m_udf = 1'b1;
      if (rd_ok) m_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
      m_cnt = exp_q.size();
    end
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".cnt"},   32'(bus.cnt),          32'(m_cnt));
    check({tag, ".empty"}, 32'(bus.empty),        32'(m_cnt == 0));
    check({tag, ".full"},  32'(bus.full),         32'(m_cnt == 8));
    check({tag, ".af"},    32'(bus.almost_full),  32'(m_cnt >= 6));
    check({tag, ".ae"},    32'(bus.almost_empty), 32'(m_cnt <= 2));
    check({tag, ".ovf"},   32'(bus.overflow),     32'(m_ovf));
    check({tag, ".udf"},   32'(bus.underflow),    32'(m_udf));
    check({tag, ".dout"},  32'(bus.data_out),     32'(m_dout));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".cnt"},   32'(bus.cnt),          32'd0);
    check({tag, ".empty"}, 32'(bus.empty),        32'd1);
    check({tag, ".full"},  32'(bus.full),         32'd0);
    check({tag, ".af"},    32'(bus.almost_full),  32'd0);
    check({tag, ".ae"},    32'(bus.almost_empty), 32'd1);
    check({tag, ".ovf"},   32'(bus.overflow),     32'd0);
    check({tag, ".udf"},   32'(bus.underflow),    32'd0);
    check({tag, ".dout"},  32'(bus.data_out),     32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b0;
    bus.clear   = 1'b0;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b1;

`ifdef SC_FIFO_FWFT_EN
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwft_wr_edge_n.cnt",   32'(bus.cnt),   32'd1);
    check("fwft_wr_edge_n.empty", 32'(bus.empty), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("fwft_visible.dout",  32'(bus.data_out), 32'hA5);
    check("fwft_visible.empty", 32'(bus.empty),    32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop.empty", 32'(bus.empty), 32'd1);
    check("fwft_pop.cnt",   32'(bus.cnt),   32'd0);

    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hB3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("fwft_head.dout", 32'(bus.data_out), 32'hB1);
    check("fwft_head.cnt",  32'(bus.cnt),      32'd3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop1.dout",  32'(bus.data_out), 32'hB2);
    check("fwft_pop1.empty", 32'(bus.empty),    32'd0);
    check("fwft_pop1.cnt",   32'(bus.cnt),      32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop2.dout", 32'(bus.data_out), 32'hB3);
    check("fwft_pop2.cnt",  32'(bus.cnt),      32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop3.empty", 32'(bus.empty), 32'd1);
    check("fwft_pop3.cnt",   32'(bus.cnt),   32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_underflow", 32'(bus.underflow), 32'd1);
`else
    // Underflow on empty, then traffic up to cnt=5 and an asynchronous reset
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("udf_empty");
    check("udf_empty.hand", 32'(bus.underflow), 32'd1);
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("pre_reset");
    check("pre_reset.cnt_hand", 32'(bus.cnt), 32'd5);
    check("pre_reset.dout_hand", 32'(bus.data_out), 32'h01);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b1;

    // Fill to full, simultaneous read+write at full, then overflow
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      check_status($sformatf("fill%0d", i));
    end
    check("full.hand", 32'(bus.full), 32'd1);
    check("full.af_hand", 32'(bus.almost_full), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(8'h21 + i), 1'b1, 1'b0);
      check_status($sformatf("full_rw%0d", i));
      check($sformatf("full_rw%0d.dout_hand", i), 32'(bus.data_out), 32'(8'h11 + i));
    end
    step(1'b1, 8'h19, 1'b0, 1'b0);
    check_status("overflow");
    check("overflow.hand", 32'(bus.overflow), 32'd1);
    check("overflow.cnt_hand", 32'(bus.cnt), 32'd8);

    // Drain across the pointer wrap, then one read too many
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_status($sformatf("drain%0d", i));
    end
    check("drain_last.dout_hand", 32'(bus.data_out), 32'h23);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("drain_extra");
    check("drain_extra.dout_hand", 32'(bus.data_out), 32'h23);

    // Clear with a same-cycle write: the word is dropped and flags reset
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check_status("clear");
    check("clear.cnt_hand", 32'(bus.cnt), 32'd0);
    check("clear.empty_hand", 32'(bus.empty), 32'd1);

    // 12 interleaved write/read pairs from cleared pointers
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_status($sformatf("ilv%0d", i));
      check($sformatf("ilv%0d.dout_hand", i), 32'(bus.data_out), 32'(8'h30 + i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("ilv_extra");
    check("ilv_extra.udf_hand", 32'(bus.underflow), 32'd1);
    check("ilv_extra.dout_hand", 32'(bus.data_out), 32'h3B);
`endif

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
